// File: rtl/fact_job_sequencer.sv
// Round-robin bus master that runs factorial jobs on a shared 4-register accelerator.
// Each granted job writes n, sets start, polls for done, reads the result, clears start and waits for idle.
module fact_job_sequencer #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_n,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_result,
    output logic                 rsp_error,
    output logic                 busy,
    output logic [1:0]           acc_addr,
    output logic [31:0]          acc_din,
    output logic                 acc_we,
    input  logic [31:0]          acc_dout
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_N, S_WR_GO, S_POLL_DONE, S_RD_RES, S_WR_CLR, S_POLL_IDLE, S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [31:0]     n_q, n_d;
    logic [IW-1:0]   id_q, id_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [31:0]     res_q, res_d;
    logic            err_q, err_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic            rsp_error_q, rsp_error_d;

    logic            any_req;
    logic [IW-1:0]   grant;
    logic [IW:0]     cand;

    // Rotating priority: the search starts one past the last granted requester.
    always_comb begin
        any_req = 1'b0;
        grant   = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
            if (!any_req && req_valid[cand[IW-1:0]]) begin
                any_req = 1'b1;
                grant   = cand[IW-1:0];
            end
        end
    end

    // NOTE: every flop uses non-blocking assignment so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            n_q          <= '0;
            id_q         <= '0;
            rr_q         <= IW'(NREQ - 1);
            res_q        <= '0;
            err_q        <= 1'b0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            n_q          <= n_d;
            id_q         <= id_d;
            rr_q         <= rr_d;
            res_q        <= res_d;
            err_q        <= err_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    // NOTE: each _d starts as its _q so no path through the case leaves a value unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        n_d          = n_q;
        id_d         = id_q;
        rr_d         = rr_q;
        res_d        = res_q;
        err_d        = err_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        unique case (state_q)
            S_IDLE: if (any_req) begin
                n_d     = req_n[32*grant +: 32];
                id_d    = grant;
                rr_d    = grant;
                state_d = S_WR_N;
            end
            S_WR_N:  state_d = S_WR_GO;
            S_WR_GO: begin
                state_d = S_POLL_DONE;
                timer_d = '0;
            end
            S_POLL_DONE: begin
                if (acc_dout[1] || (!acc_dout[0] && timer_q == TLAST)) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = S_WR_CLR;
                end else if (acc_dout[0]) begin
                    state_d = S_RD_RES;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RD_RES: begin
                res_d   = acc_dout;
                err_d   = 1'b0;
                state_d = S_WR_CLR;
            end
            S_WR_CLR: begin
                state_d = S_POLL_IDLE;
                timer_d = '0;
            end
            S_POLL_IDLE: begin
                if (acc_dout[1:0] == 2'b00) begin
                    state_d = S_RESP;
                end else if (timer_q == TLAST) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: state_d = S_IDLE;
        endcase
        if (state_q == S_POLL_IDLE && state_d == S_RESP) begin
            rsp_result_d = res_d;
            rsp_error_d  = err_d;
        end
    end

    // Outputs are forced to zero while reset is held, including the IDLE status address.
    always_comb begin
        acc_addr  = 2'd0;
        acc_din   = '0;
        acc_we    = 1'b0;
        busy      = 1'b0;
        rsp_valid = '0;
        req_ready = '0;
        if (!reset) begin
            busy = (state_q != S_IDLE);
            unique case (state_q)
                S_IDLE: begin
                    acc_addr = 2'd2;
                    if (any_req) req_ready[grant] = 1'b1;
                end
                S_WR_N: begin
                    acc_addr = 2'd0;
                    acc_din  = n_q;
                    acc_we   = 1'b1;
                end
                S_WR_GO: begin
                    acc_addr = 2'd3;
                    acc_din  = 32'd1;
                    acc_we   = 1'b1;
                end
                S_POLL_DONE, S_POLL_IDLE: acc_addr = 2'd2;
                S_RD_RES: acc_addr = 2'd1;
                S_WR_CLR: begin
                    acc_addr = 2'd3;
                    acc_we   = 1'b1;
                end
                S_RESP: begin
                    acc_addr        = 2'd2;
                    rsp_valid[id_q] = 1'b1;
                end
            endcase
        end
    end

    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;

endmodule

// File: tb/tb_fact_job_sequencer.sv
// Bench for fact_job_sequencer: accelerator model, job-level reference model with a per-cycle
// compare process, and directed jobs with hand-computed results and latencies.
module tb_fact_job_sequencer;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*32-1:0]  req_n;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_result;
    logic                rsp_error;
    logic                busy;
    logic [1:0]          acc_addr;
    logic [31:0]         acc_din;
    logic                acc_we;
    logic [31:0]         acc_dout;

    fact_job_sequencer #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .busy(busy), .acc_addr(acc_addr), .acc_din(acc_din), .acc_we(acc_we),
        .acc_dout(acc_dout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [31:0] fact(input logic [31:0] n);
        logic [31:0] p = 32'd1;
        for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
        return p;
    endfunction

    // Accelerator: start latched one cycle after control is set, result one cycle later.
    logic [31:0] acc_in, acc_res;
    logic        acc_ctrl, acc_done, acc_err;
    int          acc_stage;
    bit          stub_stuck;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_in <= '0; acc_res <= '0; acc_ctrl <= 1'b0;
            acc_done <= 1'b0; acc_err <= 1'b0; acc_stage <= 0;
        end else begin
            if (acc_we && acc_addr == 2'd0) acc_in <= acc_din;
            if (acc_we && acc_addr == 2'd3) acc_ctrl <= acc_din[0];
            case (acc_stage)
                0: if (acc_ctrl) acc_stage <= 1;
                1: begin
                    if (acc_in > 32'd12) acc_err <= 1'b1;
                    else begin acc_res <= fact(acc_in); acc_done <= 1'b1; end
                    acc_stage <= 2;
                end
                default: if (!acc_ctrl) begin
                    acc_done <= 1'b0; acc_err <= 1'b0; acc_stage <= 0;
                end
            endcase
        end
    end

    always_comb begin
        acc_dout = '0;
        case (acc_addr)
            2'd0: acc_dout = acc_in;
            2'd1: acc_dout = acc_res;
            2'd2: acc_dout = stub_stuck ? 32'd0 : {30'd0, acc_err, acc_done};
            default: acc_dout = {31'd0, acc_ctrl};
        endcase
    end

    // Reference model: one planned bus step per cycle after acceptance.
    typedef struct {
        logic [1:0]  addr;
        bit          chk_addr;
        bit          we;
        logic [31:0] din;
        bit          rsp;
        int          id;
        logic [31:0] res;
        bit          err;
    } step_t;

    step_t       plan_q[$];
    int          m_rr;
    logic [31:0] m_res;
    logic        m_err;

    function automatic void push_step(input logic [1:0] a, input bit ca, input bit we,
                                      input logic [31:0] d, input bit rsp, input int id,
                                      input logic [31:0] r, input bit e);
        step_t s;
        s.addr = a; s.chk_addr = ca; s.we = we; s.din = d;
        s.rsp = rsp; s.id = id; s.res = r; s.err = e;
        plan_q.push_back(s);
    endfunction

    function automatic void plan_job(input int id, input logic [31:0] n);
        logic [31:0] r;
        bit          e;
        int          pd, pi;
        if (stub_stuck)       begin e = 1'b1; r = '0;      pd = TIMEOUT; pi = 1; end
        else if (n > 32'd12)  begin e = 1'b1; r = '0;      pd = 3;       pi = 2; end
        else                  begin e = 1'b0; r = fact(n); pd = 3;       pi = 2; end
        push_step(2'd0, 1, 1, n, 0, id, r, e);
        push_step(2'd3, 1, 1, 32'd1, 0, id, r, e);
        for (int i = 0; i < pd; i++) push_step(2'd2, 1, 0, '0, 0, id, r, e);
        if (!e) push_step(2'd1, 1, 0, '0, 0, id, r, e);
        push_step(2'd3, 1, 1, 32'd0, 0, id, r, e);
        for (int i = 0; i < pi; i++) push_step(2'd2, 1, 0, '0, 0, id, r, e);
        push_step(2'd0, 0, 0, '0, 1, id, r, e);
    endfunction

    initial begin : compare
        int    g;
        step_t s;
        m_rr = NREQ - 1; m_res = '0; m_err = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_busy", 32'(busy), 0);
                check("rst_acc_addr", 32'(acc_addr), 0);
                check("rst_acc_we", 32'(acc_we), 0);
                check("rst_acc_din", acc_din, 0);
                check("rst_rsp_valid", 32'(rsp_valid), 0);
                check("rst_req_ready", 32'(req_ready), 0);
                plan_q.delete();
                m_rr = NREQ - 1; m_res = '0; m_err = 1'b0;
            end else if (plan_q.size() == 0) begin
                check("idle_busy", 32'(busy), 0);
                check("idle_acc_addr", 32'(acc_addr), 2);
                check("idle_acc_we", 32'(acc_we), 0);
                check("idle_rsp_valid", 32'(rsp_valid), 0);
                g = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (m_rr + k) % NREQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
                check("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
                if (g >= 0) begin
                    m_rr = g;
                    plan_job(g, req_n[32*g +: 32]);
                end
            end else begin
                s = plan_q.pop_front();
                check("job_busy", 32'(busy), 1);
                check("job_req_ready", 32'(req_ready), 0);
                check("job_acc_we", 32'(acc_we), 32'(s.we));
                if (s.chk_addr) check("job_acc_addr", 32'(acc_addr), 32'(s.addr));
                if (s.we) check("job_acc_din", acc_din, s.din);
                check("job_rsp_valid", 32'(rsp_valid), s.rsp ? (32'd1 << s.id) : 32'd0);
                if (s.rsp) begin m_res = s.res; m_err = s.err; end
            end
            check("rsp_result", rsp_result, m_res);
            check("rsp_error", 32'(rsp_error), 32'(m_err));
        end
    end

    // Runs one job from requester id; latency counts cycles from the accept cycle (cycle 0).
    task automatic run_job(input int id, input logic [31:0] n, input logic [31:0] exp_res,
                           input logic exp_err, input int exp_lat, input string name);
        int cyc;
        bit got;
        @(posedge clk); #1;
        req_valid[id] = 1'b1;
        req_n[32*id +: 32] = n;
        got = 0; cyc = 0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
            else begin cyc++; @(posedge clk); #1; end
        end
        check({name, "_accept"}, 32'(got), 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        got = 0; cyc = 1;
        while (!got && cyc < 64) begin
            @(negedge clk);
            if (rsp_valid[id]) got = 1;
            else begin @(posedge clk); #1; cyc++; end
        end
        check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({name, "_result"}, rsp_result, exp_res);
        check({name, "_error"}, 32'(rsp_error), 32'(exp_err));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk); #2;
        reset = 1'b0;
    endtask

    logic [31:0] got_id [4];
    logic [31:0] got_res[4];

    initial begin : directed
        int cnt, cyc;
        reset = 1'b1; req_valid = '0; req_n = '0; stub_stuck = 0;
        #2;
        check("por_busy", 32'(busy), 0);
        check("por_acc_addr", 32'(acc_addr), 0);
        check("por_rsp_result", rsp_result, 0);
        #20 reset = 1'b0;

        run_job(0, 32'd5, 32'd120, 1'b0, 10, "n5");
        run_job(0, 32'd0, 32'd1, 1'b0, 10, "n0");
        run_job(1, 32'd12, 32'd479001600, 1'b0, 10, "n12");
        run_job(0, 32'd13, 32'd0, 1'b1, 9, "n13");
        run_job(0, 32'd3, 32'd6, 1'b0, 10, "n3_after_err");

        // Both requesters held: grants must alternate starting with 0.
        pulse_reset();
        @(posedge clk); #1;
        req_n = {32'd6, 32'd4};
        req_valid = 2'b11;
        cnt = 0; cyc = 0;
        while (cnt < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (|rsp_valid) begin
                got_id[cnt]  = 32'(rsp_valid);
                got_res[cnt] = rsp_result;
                cnt++;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        check("alt_count", 32'(cnt), 4);
        check("alt0_owner", got_id[0], 1); check("alt0_result", got_res[0], 24);
        check("alt1_owner", got_id[1], 2); check("alt1_result", got_res[1], 720);
        check("alt2_owner", got_id[2], 1); check("alt2_result", got_res[2], 24);
        check("alt3_owner", got_id[3], 2); check("alt3_result", got_res[3], 720);

        // Status stuck at zero: POLL_DONE runs TIMEOUT cycles, then clear and a one-cycle idle poll.
        stub_stuck = 1;
        run_job(0, 32'd5, 32'd0, 1'b1, 13, "timeout");
        stub_stuck = 0;

        // Reset in the middle of POLL_DONE.
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        req_n[31:0] = 32'd9;
        @(negedge clk);
        check("mr_accept", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mr_busy", 32'(busy), 0);
        check("mr_acc_addr", 32'(acc_addr), 0);
        check("mr_acc_we", 32'(acc_we), 0);
        check("mr_rsp_result", rsp_result, 0);
        check("mr_rsp_error", 32'(rsp_error), 0);
        @(negedge clk);
        @(negedge clk); #2;
        reset = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (|rsp_valid) cnt++;
        end
        check("mr_no_response", 32'(cnt), 0);
        run_job(0, 32'd7, 32'd5040, 1'b0, 10, "after_reset");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
